vga_timing_gen: RTL and testbench

Parametrised VGA timing generator and next generation of the fixed 640x480 `vga_sync`. It adds configurable horizontal/vertical timing, a configurable pixel-clock divider, configurable sync polarity and coordinate width, a pixel-rate `enable`, and `line_start`/`frame_start` strobes. It sits between the system clock and the pixel pipeline (pattern/logo renderers, RGB output register), which samples coordinates on `p_tick`.

---
 rtl/vga_timing_pkg.sv | 36 +++
 rtl/pixel_tick_gen.sv | 28 ++
 rtl/vga_timing_gen.sv | 79 +++++++
 tb/tb_vga_timing_gen.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and the sync-window decode helper.
package vga_timing_pkg;

  // 640x480, 800x525 total; matches the vga_timing_gen defaults.
  localparam int unsigned VGA640_H_DISPLAY = 640;
  localparam int unsigned VGA640_H_FRONT   = 16;
  localparam int unsigned VGA640_H_SYNC    = 96;
  localparam int unsigned VGA640_H_BACK    = 48;
  localparam int unsigned VGA640_V_DISPLAY = 480;
  localparam int unsigned VGA640_V_FRONT   = 10;
  localparam int unsigned VGA640_V_SYNC    = 2;
  localparam int unsigned VGA640_V_BACK    = 33;
  localparam bit          VGA640_HSYNC_POL = 1'b0;
  localparam bit          VGA640_VSYNC_POL = 1'b0;

  // 800x600, 1056x628 total, positive syncs.
  localparam int unsigned SVGA800_H_DISPLAY = 800;
  localparam int unsigned SVGA800_H_FRONT   = 40;
  localparam int unsigned SVGA800_H_SYNC    = 128;
  localparam int unsigned SVGA800_H_BACK    = 88;
  localparam int unsigned SVGA800_V_DISPLAY = 600;
  localparam int unsigned SVGA800_V_FRONT   = 1;
  localparam int unsigned SVGA800_V_SYNC    = 4;
  localparam int unsigned SVGA800_V_BACK    = 23;
  localparam bit          SVGA800_HSYNC_POL = 1'b1;
  localparam bit          SVGA800_VSYNC_POL = 1'b1;

  // Output level of a sync line: pol inside [start, start+len), !pol outside.
  function automatic logic sync_level(input int unsigned pos,
                                      input int unsigned start,
                                      input int unsigned len,
                                      input logic        pol);
    return ((pos >= start) && (pos < start + len)) ? pol : ~pol;
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// System-clock to pixel-rate divider producing the one-clk p_tick strobe.
module pixel_tick_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic p_tick
);

  localparam int unsigned   DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;

  // Divider phase advances only while enabled, so a pause resumes mid-pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if (enable) begin
      div <= (div == DIV_LAST) ? '0 : div + 1'b1;
    end
  end

  // Reset gating keeps p_tick low during reset even when CLK_DIV is 1.
  assign p_tick = enable && !reset && (div == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel counters plus registered sync/video decode.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned CW        = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          p_tick,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int unsigned   H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned   V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);

  logic [CW-1:0] next_x;
  logic [CW-1:0] next_y;

  pixel_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .p_tick(p_tick)
  );

  // Coordinate the counters move to on the next pixel tick.
  always_comb begin
    next_x = pixel_x + 1'b1;
    next_y = pixel_y;
    if (pixel_x == H_LAST) begin
      next_x = '0;
      next_y = (pixel_y == V_LAST) ? '0 : pixel_y + 1'b1;
    end
  end

  // Sync/video flops decode the coordinate being loaded, so they always
  // describe the presented pixel with zero lag behind the counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_x  <= H_LAST;
      pixel_y  <= V_LAST;
      video_on <= 1'b0;
      hsync    <= !HSYNC_POL;
      vsync    <= !VSYNC_POL;
    end else if (p_tick) begin
      pixel_x  <= next_x;
      pixel_y  <= next_y;
      video_on <= (32'(next_x) < H_DISPLAY) && (32'(next_y) < V_DISPLAY);
      hsync    <= sync_level(32'(next_x), H_DISPLAY + H_FRONT, H_SYNC, HSYNC_POL);
      vsync    <= sync_level(32'(next_y), V_DISPLAY + V_FRONT, V_SYNC, VSYNC_POL);
    end
  end

  assign line_start  = p_tick && (pixel_x == '0);
  assign frame_start = line_start && (pixel_y == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: three configurations against a linear-pixel-index reference model.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  typedef struct {
    int unsigned div, hd, hf, hs, hb, vd, vf, vs, vb;
    bit          hp, vp;
  } cfg_t;

  typedef struct {
    logic [31:0] x, y;
    logic        vid, hs, vs, pt, ls, fs;
  } obs_t;

  logic       clk;
  logic       reset;
  logic [2:0] en;

  logic       hs0, vs0, vid0, pt0, ls0, fs0;
  logic [9:0] x0, y0;
  logic       hs1, vs1, vid1, pt1, ls1, fs1;
  logic [10:0] x1, y1;
  logic       hs2, vs2, vid2, pt2, ls2, fs2;
  logic [4:0] x2, y2;

  cfg_t cfg [3];
  int   e [3];
  int   n_cmp = 0;
  int   n_bad = 0;

  vga_timing_gen dut0 (
    .clk(clk), .reset(reset), .enable(en[0]), .hsync(hs0), .vsync(vs0),
    .video_on(vid0), .p_tick(pt0), .pixel_x(x0), .pixel_y(y0),
    .line_start(ls0), .frame_start(fs0)
  );

  vga_timing_gen #(
    .CLK_DIV(1),
    .H_DISPLAY(SVGA800_H_DISPLAY), .H_FRONT(SVGA800_H_FRONT),
    .H_SYNC(SVGA800_H_SYNC), .H_BACK(SVGA800_H_BACK),
    .V_DISPLAY(SVGA800_V_DISPLAY), .V_FRONT(SVGA800_V_FRONT),
    .V_SYNC(SVGA800_V_SYNC), .V_BACK(SVGA800_V_BACK),
    .HSYNC_POL(SVGA800_HSYNC_POL), .VSYNC_POL(SVGA800_VSYNC_POL),
    .CW(11)
  ) dut1 (
    .clk(clk), .reset(reset), .enable(en[1]), .hsync(hs1), .vsync(vs1),
    .video_on(vid1), .p_tick(pt1), .pixel_x(x1), .pixel_y(y1),
    .line_start(ls1), .frame_start(fs1)
  );

  vga_timing_gen #(
    .CLK_DIV(3),
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0),
    .CW(5)
  ) dut2 (
    .clk(clk), .reset(reset), .enable(en[2]), .hsync(hs2), .vsync(vs2),
    .video_on(vid2), .p_tick(pt2), .pixel_x(x2), .pixel_y(y2),
    .line_start(ls2), .frame_start(fs2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: after e enabled clks there have been e/div pixel ticks; the
  // presented pixel is linear index (ticks-1) mod frame size, reset = last pixel.
  function automatic obs_t model(input cfg_t c, input int ec, input logic enc, input logic rst);
    obs_t        m;
    int unsigned ht, vt, frame, k, l;
    ht    = c.hd + c.hf + c.hs + c.hb;
    vt    = c.vd + c.vf + c.vs + c.vb;
    frame = ht * vt;
    k     = int'(ec) / c.div;
    l     = (k + frame - 1) % frame;
    m.x   = l % ht;
    m.y   = l / ht;
    m.vid = (m.x < c.hd) && (m.y < c.vd);
    m.hs  = ((m.x >= c.hd + c.hf) && (m.x < c.hd + c.hf + c.hs)) ? c.hp : !c.hp;
    m.vs  = ((m.y >= c.vd + c.vf) && (m.y < c.vd + c.vf + c.vs)) ? c.vp : !c.vp;
    m.pt  = !rst && enc && ((int'(ec) % c.div) == c.div - 1);
    m.ls  = m.pt && (m.x == 0);
    m.fs  = m.ls && (m.y == 0);
    return m;
  endfunction

  function automatic obs_t get_obs(input int i);
    obs_t o;
    case (i)
      0:       o = '{32'(x0), 32'(y0), vid0, hs0, vs0, pt0, ls0, fs0};
      1:       o = '{32'(x1), 32'(y1), vid1, hs1, vs1, pt1, ls1, fs1};
      default: o = '{32'(x2), 32'(y2), vid2, hs2, vs2, pt2, ls2, fs2};
    endcase
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all(input logic rst);
    obs_t o, m;
    for (int i = 0; i < 3; i++) begin
      o = get_obs(i);
      m = model(cfg[i], e[i], en[i], rst);
      check($sformatf("d%0d.pixel_x", i), o.x, m.x);
      check($sformatf("d%0d.pixel_y", i), o.y, m.y);
      check($sformatf("d%0d.video_on", i), 32'(o.vid), 32'(m.vid));
      check($sformatf("d%0d.hsync", i), 32'(o.hs), 32'(m.hs));
      check($sformatf("d%0d.vsync", i), 32'(o.vs), 32'(m.vs));
      check($sformatf("d%0d.p_tick", i), 32'(o.pt), 32'(m.pt));
      check($sformatf("d%0d.line_start", i), 32'(o.ls), 32'(m.ls));
      check($sformatf("d%0d.frame_start", i), 32'(o.fs), 32'(m.fs));
    end
  endtask

  task automatic step_model();
    for (int i = 0; i < 3; i++) begin
      if (!reset && en[i]) e[i]++;
    end
  endtask

  initial begin
    int   fs0_clk, ls0_a, ls0_b, fs2_last, hs1_cnt, hold0, rst_hold;
    bit   ls1_seen, dropped;
    obs_t m0;

    cfg[0] = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    cfg[1] = '{1, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1};
    cfg[2] = '{3, 8, 2, 3, 3, 6, 2, 2, 3, 1'b1, 1'b0};
    e      = '{0, 0, 0};
    reset  = 1'b1;
    en     = 3'b111;
    fs0_clk = -1; ls0_a = -1; ls0_b = -1; fs2_last = -1;
    hs1_cnt = 0; ls1_seen = 0; dropped = 0; hold0 = 0; rst_hold = 0;

    // Reset held: outputs sit at the last pixel of the frame.
    repeat (3) begin
      @(negedge clk);
      compare_all(1'b1);
    end
    reset = 1'b0;

    // Directed run with enables high; one 37-clk pause on dut0 at (100,1).
    for (int c = 1; c <= 2300; c++) begin
      @(posedge clk);
      step_model();
      @(negedge clk);
      compare_all(1'b0);
      if (fs0 && fs0_clk < 0) fs0_clk = c + 1;
      if (ls0) begin
        if (ls0_a < 0) ls0_a = c;
        else if (ls0_b < 0) ls0_b = c;
      end
      if (fs2) begin
        if (fs2_last >= 0) check("d2.frame_period", 32'(c - fs2_last), 32'd624);
        fs2_last = c;
      end
      if (ls1) begin
        if (ls1_seen) check("d1.hsync_active_clks", 32'(hs1_cnt), 32'd128);
        hs1_cnt  = 0;
        ls1_seen = 1;
      end
      if (hs1) hs1_cnt++;
      if (hold0 > 0) begin
        check("d0.pause_x", 32'(x0), 32'd100);
        hold0--;
        if (hold0 == 0) en[0] = 1'b1;
      end else if (!dropped) begin
        m0 = model(cfg[0], e[0], en[0], 1'b0);
        if (m0.x == 100 && m0.y == 1 && !m0.pt) begin
          en[0]   = 1'b0;
          hold0   = 37;
          dropped = 1;
        end
      end
    end
    check("d0.first_frame_start_clk", 32'(fs0_clk), 32'd4);
    check("d0.line_period", 32'(ls0_b - ls0_a), 32'd1600);
    check("d0.pause_taken", 32'(dropped), 32'd1);
    en = 3'b111;

    // Randomised enables with occasional asynchronous mid-cycle resets.
    for (int c = 0; c < 18000; c++) begin
      en[0] = ($urandom_range(0, 3) != 0);
      en[1] = ($urandom_range(0, 15) != 0);
      en[2] = ($urandom_range(0, 2) != 0);
      if (reset) begin
        if (rst_hold == 0) reset = 1'b0;
        else rst_hold--;
      end else if ($urandom_range(0, 1499) == 0) begin
        #2;
        reset = 1'b1;
        e     = '{0, 0, 0};
        #1;
        compare_all(1'b1);
        rst_hold = int'($urandom_range(0, 2));
      end
      @(posedge clk);
      step_model();
      @(negedge clk);
      compare_all(reset);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
